// File: rtl/time_set_controller.sv
// ---------------------------------------------------------------------------
// time_set_controller
//
// Button-driven editor for a 12-hour clock's set-time port. A mode press in
// IDLE captures the clock's current time. The user then walks through the
// hour, minute and AM/PM fields, incrementing each one with inc presses. A
// final mode press issues a one-cycle write strobe that carries the edited
// values. A cancel press or an inactivity timeout abandons the edit without
// issuing a strobe.
//
// Optional feature: define AUTO_REPEAT_EN to make a held inc button
// auto-repeat in the hour and minute fields.
//
// Parameters:
//   TIMEOUT       idle cycles in an edit field before automatic abort (>= 1)
//   REPEAT_DELAY  held cycles after the press edge before auto-repeat starts
//   REPEAT_RATE   cycles between auto-repeat increments (>= 1)
//
// Ports:
//   Clk_1sec       system clock, all logic on the rising edge
//   reset_in       synchronous active-high reset
//   mode_btn_in    enter edit / advance field
//   inc_btn_in     increment the current field
//   cancel_btn_in  abort the edit without writing
//   cur_hour_in    clock's current hour (1..12)
//   cur_minute_in  clock's current minute (0..59)
//   cur_ampm_in    clock's current AM/PM (0 = AM, 1 = PM)
//   set_time_out   one-cycle write strobe
//   set_hour_out   edited hour
//   set_minute_out edited minute
//   set_ampm_out   edited AM/PM
//   editing_out    high while an edit field is selected
//   field_sel_out  0 none, 1 hour, 2 minute, 3 AM/PM
// ---------------------------------------------------------------------------
module time_set_controller #(
    parameter int unsigned TIMEOUT      = 30,
    parameter int unsigned REPEAT_DELAY = 3,
    parameter int unsigned REPEAT_RATE  = 1
) (
    input  logic       Clk_1sec,
    input  logic       reset_in,
    input  logic       mode_btn_in,
    input  logic       inc_btn_in,
    input  logic       cancel_btn_in,
    input  logic [3:0] cur_hour_in,
    input  logic [5:0] cur_minute_in,
    input  logic       cur_ampm_in,
    output logic       set_time_out,
    output logic [3:0] set_hour_out,
    output logic [5:0] set_minute_out,
    output logic       set_ampm_out,
    output logic       editing_out,
    output logic [1:0] field_sel_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOUR,
        S_MIN,
        S_AMPM,
        S_COMMIT
    } state_e;

    localparam int unsigned TO_W = $clog2(TIMEOUT + 2);

    state_e          state_q, state_d;
    logic [3:0]      hour_q, hour_d;
    logic [5:0]      min_q, min_d;
    logic            ampm_q, ampm_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            strobe_q, editing_q;
    logic [1:0]      field_q, field_d;
    logic            mode_hist_q, inc_hist_q, cancel_hist_q;
    logic            mode_press, inc_press, cancel_press;
    logic            rep_fire;

    // A press is the first cycle a button samples high; the history register
    // holds the previous sample.
    assign mode_press   = mode_btn_in & ~mode_hist_q;
    assign inc_press    = inc_btn_in & ~inc_hist_q;
    assign cancel_press = cancel_btn_in & ~cancel_hist_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RP_MAX = REPEAT_DELAY + REPEAT_RATE;
    localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

    logic [RP_W-1:0] rep_q, rep_d;

    // rep_q counts held cycles since the press edge. Once it reaches
    // DELAY+RATE it fires and falls back to DELAY, so later repeats land
    // every RATE cycles. A mode or cancel press restarts the count.
    always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if (inc_btn_in && inc_hist_q && !mode_press && !cancel_press &&
            (state_q == S_HOUR || state_q == S_MIN)) begin
            if (rep_q == RP_W'(RP_MAX - 1)) begin
                rep_fire = 1'b1;
                rep_d    = RP_W'(REPEAT_DELAY);
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_1sec) begin
        if (reset_in) rep_q <= '0;
        else          rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        ampm_d  = ampm_q;
        to_d    = '0;
        field_d = 2'd0;

        unique case (state_q)
            S_IDLE: begin
                if (mode_press) begin
                    state_d = S_HOUR;
                    hour_d  = (cur_hour_in == 4'd0 || cur_hour_in > 4'd12) ? 4'd12 : cur_hour_in;
                    min_d   = (cur_minute_in > 6'd59) ? 6'd0 : cur_minute_in;
                    ampm_d  = cur_ampm_in;
                end
            end
            S_HOUR, S_MIN, S_AMPM: begin
                if (cancel_press) begin
                    state_d = S_IDLE;
                end else if (mode_press) begin
                    case (state_q)
                        S_HOUR:  state_d = S_MIN;
                        S_MIN:   state_d = S_AMPM;
                        default: state_d = S_COMMIT;
                    endcase
                end else if (inc_press || rep_fire) begin
                    case (state_q)
                        S_HOUR:  hour_d = (hour_q == 4'd12) ? 4'd1 : hour_q + 4'd1;
                        S_MIN:   min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                        default: ampm_d = ~ampm_q;
                    endcase
                end else if (to_q >= TO_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_HOUR:  field_d = 2'd1;
            S_MIN:   field_d = 2'd2;
            S_AMPM:  field_d = 2'd3;
            default: field_d = 2'd0;
        endcase
    end

    always_ff @(posedge Clk_1sec) begin
        if (reset_in) begin
            state_q       <= S_IDLE;
            hour_q        <= 4'd12;
            min_q         <= '0;
            ampm_q        <= 1'b0;
            to_q          <= '0;
            strobe_q      <= 1'b0;
            editing_q     <= 1'b0;
            field_q       <= 2'd0;
            mode_hist_q   <= 1'b0;
            inc_hist_q    <= 1'b0;
            cancel_hist_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hour_q        <= hour_d;
            min_q         <= min_d;
            ampm_q        <= ampm_d;
            to_q          <= to_d;
            strobe_q      <= (state_d == S_COMMIT);
            editing_q     <= (field_d != 2'd0);
            field_q       <= field_d;
            mode_hist_q   <= mode_btn_in;
            inc_hist_q    <= inc_btn_in;
            cancel_hist_q <= cancel_btn_in;
        end
    end

    assign set_time_out   = strobe_q;
    assign set_hour_out   = hour_q;
    assign set_minute_out = min_q;
    assign set_ampm_out   = ampm_q;
    assign editing_out    = editing_q;
    assign field_sel_out  = field_q;

endmodule
